// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus. It drives per-requester enables and
// keeps an arm cycle before each drive and a turnaround cycle between owners.
module tristate_bus_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned HOLD_MAX = 8,
   localparam int unsigned ID_W    = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] bus_en,
   output logic [ID_W-1:0]  owner_id,
   output logic             busy,
   output logic             timeout
);

   localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {StIdle, StArm, StDrive, StTurn} state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic [CNT_W-1:0]   hold_q, hold_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   bus_en_q, bus_en_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               pick_found;
   logic [ID_W-1:0]    pick_idx;
   int unsigned        scan_idx;
   logic               owner_req;
   logic [ID_W-1:0]    owner_next;

   // First asserted request scanning upward from the round-robin pointer.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = 0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         scan_idx = (32'(rr_q) + off) % N_REQ;
         if (!pick_found && req[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = ID_W'(scan_idx);
         end
      end
   end

   assign owner_req  = req[owner_q];
   assign owner_next = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      bus_en_d  = bus_en_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      unique case (state_q)
         StIdle, StTurn: begin
            if (pick_found) begin
               state_d = StArm;
               grant_d = N_REQ'(1) << pick_idx;
               owner_d = pick_idx;
               busy_d  = 1'b1;
            end else begin
               state_d = StIdle;
               grant_d = '0;
               busy_d  = 1'b0;
            end
            bus_en_d = '0;
         end
         StArm: begin
            if (owner_req) begin
               state_d  = StDrive;
               bus_en_d = grant_q;
               hold_d   = '0;
            end else begin
               state_d = StTurn;
               grant_d = '0;
            end
         end
         StDrive: begin
            hold_d = hold_q + CNT_W'(1);
            if (!owner_req || hold_q == CNT_W'(HOLD_MAX - 1)) begin
               state_d   = StTurn;
               grant_d   = '0;
               bus_en_d  = '0;
               rr_d      = owner_next;
               // A release that coincides with the owner dropping req is not forced.
               timeout_d = owner_req;
            end
         end
         default: begin
            state_d  = StIdle;
            grant_d  = '0;
            bus_en_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         rr_q      <= '0;
         owner_q   <= '0;
         hold_q    <= '0;
         grant_q   <= '0;
         bus_en_q  <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         bus_en_q  <= bus_en_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant    = grant_q;
   assign bus_en   = bus_en_q;
   assign owner_id = owner_q;
   assign busy     = busy_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: a tenure-level model queues expected outputs,
// a monitor compares them after every clock edge and checks bus-safety invariants.
module tb_tristate_bus_arbiter;

   localparam int NR   = 4;
   localparam int HOLD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [NR-1:0] grant;
   logic [NR-1:0] bus_en;
   logic [1:0]    owner_id;
   logic          busy;
   logic          timeout;

   tristate_bus_arbiter #(
      .N_REQ   (NR),
      .HOLD_MAX(HOLD)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .grant   (grant),
      .bus_en  (bus_en),
      .owner_id(owner_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NR-1:0] grant;
      logic [NR-1:0] bus_en;
      logic [1:0]    owner;
      logic          busy;
      logic          timeout;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Tenure-level reference: phase of the bus, who owns it, and drive cycles spent so far.
   localparam int P_IDLE = 0, P_ARM = 1, P_DRIVE = 2, P_TURN = 3;
   int m_phase, m_owner, m_ptr, m_held;
   bit m_to;

   function automatic int first_from(input logic [NR-1:0] r, input int start);
      for (int k = 0; k < NR; k++) begin
         if (r[(start + k) % NR]) return (start + k) % NR;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE;
      m_owner = 0;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 0;
   endtask

   task automatic model_step(input logic [NR-1:0] r);
      int w;
      m_to = 0;
      case (m_phase)
         P_IDLE, P_TURN: begin
            w = first_from(r, m_ptr);
            if (w >= 0) begin
               m_phase = P_ARM;
               m_owner = w;
            end else begin
               m_phase = P_IDLE;
            end
         end
         P_ARM: begin
            if (r[m_owner]) begin
               m_phase = P_DRIVE;
               m_held  = 1;
            end else begin
               m_phase = P_TURN;
            end
         end
         default: begin
            if (!r[m_owner] || m_held == HOLD) begin
               m_to    = r[m_owner];
               m_phase = P_TURN;
               m_ptr   = (m_owner + 1) % NR;
            end else begin
               m_held++;
            end
         end
      endcase
   endtask

   function automatic exp_t model_out();
      exp_t e;
      logic [NR-1:0] sel;
      sel       = '0;
      sel[m_owner] = 1'b1;
      e.grant   = (m_phase == P_ARM || m_phase == P_DRIVE) ? sel : '0;
      e.bus_en  = (m_phase == P_DRIVE) ? sel : '0;
      e.owner   = 2'(m_owner);
      e.busy    = (m_phase != P_IDLE);
      e.timeout = m_to;
      return e;
   endfunction

   // Called at a falling edge: applies req for the next rising edge and queues the result.
   task automatic cycle(input logic [NR-1:0] r);
      req = r;
      model_step(r);
      exp_q.push_back(model_out());
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_bus_en", bus_en, 0);
      chk("async_reset_grant", grant, 0);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_owner", owner_id, 0);
      chk("async_reset_timeout", timeout, 0);
      model_reset();
      req = '0;
      exp_q.push_back(model_out());
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compares queued expectations and checks invariants after each rising edge.
   int cyc = 0;
   int last_drv_owner = -1;
   int last_drv_cyc = 0;
   always begin
      exp_t e;
      int cur;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("grant", grant, e.grant);
         chk("bus_en", bus_en, e.bus_en);
         chk("owner_id", owner_id, e.owner);
         chk("busy", busy, e.busy);
         chk("timeout", timeout, e.timeout);
      end
      chk("onehot0_grant", $onehot0(grant), 1);
      chk("onehot0_bus_en", $onehot0(bus_en), 1);
      chk("bus_en_subset_grant", bus_en & ~grant, 0);
      if (bus_en != 0) begin
         cur = 0;
         for (int i = 0; i < NR; i++) if (bus_en[i]) cur = i;
         if (last_drv_owner >= 0 && cur != last_drv_owner)
            chk("owner_change_gap", (cyc - last_drv_cyc) >= 3, 1);
         last_drv_owner = cur;
         last_drv_cyc   = cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NR-1:0] r;
      rst_n = 1'b0;
      req   = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Reset mid-DRIVE, then restart from IDLE.
      repeat (3) cycle(4'b0001);
      do_reset();
      repeat (3) cycle(4'b0001);
      repeat (3) cycle(4'b0000);

      // Single request held for two drive cycles.
      repeat (3) cycle(4'b0100);
      repeat (3) cycle(4'b0000);

      // Fairness with all requesters held.
      repeat (30) cycle(4'b1111);
      repeat (3) cycle(4'b0000);

      // Late-arriving requester.
      repeat (4) cycle(4'b0011);
      repeat (24) cycle(4'b0111);
      repeat (3) cycle(4'b0000);

      // ARM abort.
      cycle(4'b1000);
      repeat (4) cycle(4'b0000);

      // Sole requester times out and is re-granted.
      repeat (14) cycle(4'b0010);
      repeat (3) cycle(4'b0000);

      // Request drops on the same edge the limit is reached.
      repeat (HOLD + 1) cycle(4'b0010);
      repeat (3) cycle(4'b0000);

      // Randomized requests with sticky bits.
      r = '0;
      for (int n = 0; n < 600; n++) begin
         for (int b = 0; b < NR; b++) if ($urandom_range(3) == 0) r[b] = ~r[b];
         if (n == 300) do_reset();
         cycle(r);
      end
      repeat (4) cycle(4'b0000);

      @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
